// File: rtl/reg_file_pkg.sv
// Shared widths, the read-port result type and the source-operand lookup
// used by both decoder read ports of the architectural register file.
package reg_file_pkg;

    localparam int REG_NUM     = 32;
    localparam int DATA_WID    = 32;
    localparam int ROB_POS_WID = 4;
    localparam int REG_POS_WID = 5;

    typedef logic [REG_POS_WID-1:0] reg_pos_t;
    typedef logic [DATA_WID-1:0]    data_t;
    typedef logic [ROB_POS_WID-1:0] rob_pos_t;

    typedef struct packed {
        data_t    val;
        logic     busy;
        rob_pos_t rob_pos;
    } query_t;

    // Resolve one source operand from stored state, forwarding a commit that
    // retires the register's current producer in this same cycle.
    function automatic query_t rd_query(
        input reg_pos_t rs,
        input data_t    st_val,
        input logic     st_busy,
        input rob_pos_t st_tag,
        input logic     wr,
        input reg_pos_t wr_rd,
        input data_t    wr_val,
        input rob_pos_t wr_pos
    );
        query_t q;
        q = '0;
        if (rs == '0) begin
            q = '0;
        end else if (wr && (wr_rd == rs) && st_busy && (st_tag == wr_pos)) begin
            q.val     = wr_val;
            q.busy    = 1'b0;
            q.rob_pos = st_tag;
        end else begin
            q.val     = st_val;
            q.busy    = st_busy;
            q.rob_pos = st_tag;
        end
        return q;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decoder/ROB-facing bus of the register file: control, issue rename,
// commit write-back and the two source-operand read ports.
interface reg_file_if;
    import reg_file_pkg::*;

    logic     rdy;
    logic     rollback;

    logic     issue;
    reg_pos_t issue_rd;
    rob_pos_t issue_rob_pos;

    logic     reg_write;
    reg_pos_t reg_rd;
    data_t    reg_val;
    rob_pos_t commit_rob_pos;

    reg_pos_t rs1;
    data_t    rs1_val;
    logic     rs1_busy;
    rob_pos_t rs1_rob_pos;

    reg_pos_t rs2;
    data_t    rs2_val;
    logic     rs2_busy;
    rob_pos_t rs2_rob_pos;

    modport master (
        output rdy, rollback,
        output issue, issue_rd, issue_rob_pos,
        output reg_write, reg_rd, reg_val, commit_rob_pos,
        output rs1, rs2,
        input  rs1_val, rs1_busy, rs1_rob_pos,
        input  rs2_val, rs2_busy, rs2_rob_pos
    );

    modport slave (
        input  rdy, rollback,
        input  issue, issue_rd, issue_rob_pos,
        input  reg_write, reg_rd, reg_val, commit_rob_pos,
        input  rs1, rs2,
        output rs1_val, rs1_busy, rs1_rob_pos,
        output rs2_val, rs2_busy, rs2_rob_pos
    );

endinterface

// File: rtl/reg_file.sv
// Architectural register file with one rename tag per register. Commits
// write values; issues mark a register busy on a ROB entry; rollback drops
// every outstanding rename. x0 is hardwired to zero.
module reg_file
    import reg_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    data_t              val_q [REG_NUM];
    data_t              val_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q, busy_d;
    rob_pos_t           tag_q [REG_NUM];
    rob_pos_t           tag_d [REG_NUM];

    query_t q1, q2;

    // Next state: commit write, then rollback or issue rename; x0 pinned to zero.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (bus.rdy) begin
            if (bus.reg_write && (bus.reg_rd != '0)) begin
                val_d[bus.reg_rd] = bus.reg_val;
                // Only retire the rename if this commit is the newest producer.
                if (busy_q[bus.reg_rd] && (tag_q[bus.reg_rd] == bus.commit_rob_pos))
                    busy_d[bus.reg_rd] = 1'b0;
            end
            if (bus.rollback) begin
                busy_d = '0;
            end else if (bus.issue && (bus.issue_rd != '0)) begin
                busy_d[bus.issue_rd] = 1'b1;
                tag_d[bus.issue_rd]  = bus.issue_rob_pos;
            end
        end
        val_d[0]  = '0;
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    // Both read ports use the same lookup with commit forwarding.
    always_comb begin
        q1 = rd_query(bus.rs1, val_q[bus.rs1], busy_q[bus.rs1], tag_q[bus.rs1],
                      bus.reg_write, bus.reg_rd, bus.reg_val, bus.commit_rob_pos);
        q2 = rd_query(bus.rs2, val_q[bus.rs2], busy_q[bus.rs2], tag_q[bus.rs2],
                      bus.reg_write, bus.reg_rd, bus.reg_val, bus.commit_rob_pos);
    end

    assign bus.rs1_val     = q1.val;
    assign bus.rs1_busy    = q1.busy;
    assign bus.rs1_rob_pos = q1.rob_pos;
    assign bus.rs2_val     = q2.val;
    assign bus.rs2_busy    = q2.busy;
    assign bus.rs2_rob_pos = q2.rob_pos;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit forwarding, stale commits,
// rollback, x0 handling, rdy freeze and asynchronous reset.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    reg_file_if bus();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue     = 1'b0;
        bus.reg_write = 1'b0;
        bus.rollback  = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] pos);
        bus.issue         = 1'b1;
        bus.issue_rd      = rd;
        bus.issue_rob_pos = pos;
        step();
        bus.issue = 1'b0;
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] pos);
        bus.reg_write      = 1'b1;
        bus.reg_rd         = rd;
        bus.reg_val        = v;
        bus.commit_rob_pos = pos;
    endtask

    task automatic chk_rs1(input string tag, input logic [4:0] rs,
                           input logic [31:0] v, input logic b, input logic [3:0] pos);
        bus.rs1 = rs;
        #1;
        check({tag, "_val"},  64'(bus.rs1_val), 64'(v));
        check({tag, "_busy"}, 64'(bus.rs1_busy), 64'(b));
        if (b) check({tag, "_pos"}, 64'(bus.rs1_rob_pos), 64'(pos));
    endtask

    task automatic chk_rs2(input string tag, input logic [4:0] rs,
                           input logic [31:0] v, input logic b, input logic [3:0] pos);
        bus.rs2 = rs;
        #1;
        check({tag, "_val"},  64'(bus.rs2_val), 64'(v));
        check({tag, "_busy"}, 64'(bus.rs2_busy), 64'(b));
        if (b) check({tag, "_pos"}, 64'(bus.rs2_rob_pos), 64'(pos));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.rdy            = 1'b1;
        bus.rollback       = 1'b0;
        bus.issue          = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_rob_pos  = '0;
        bus.reg_write      = 1'b0;
        bus.reg_rd         = '0;
        bus.reg_val        = '0;
        bus.commit_rob_pos = '0;
        bus.rs1            = 5'd7;
        bus.rs2            = 5'd0;

        // Reset state
        #1;
        chk_rs1("rst_x7", 5'd7, 32'h0, 1'b0, 4'h0);
        check("rst_x7_pos", 64'(bus.rs1_rob_pos), 64'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // Issue then commit with forwarding
        do_issue(5'd5, 4'd3);
        chk_rs1("iss_x5", 5'd5, 32'h0, 1'b1, 4'd3);
        set_commit(5'd5, 32'hDEADBEEF, 4'd3);
        chk_rs1("byp_x5", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);
        step();
        idle_inputs();
        chk_rs1("st_x5", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);

        // Stale commit leaves the younger rename in place
        do_issue(5'd5, 4'd3);
        do_issue(5'd5, 4'd7);
        set_commit(5'd5, 32'h11, 4'd3);
        chk_rs1("stale_byp", 5'd5, 32'hDEADBEEF, 1'b1, 4'd7);
        step();
        idle_inputs();
        chk_rs1("stale_st", 5'd5, 32'h11, 1'b1, 4'd7);
        set_commit(5'd5, 32'h22, 4'd7);
        step();
        idle_inputs();
        chk_rs1("young_st", 5'd5, 32'h22, 1'b0, 4'd0);

        // Same-cycle commit and issue to x9: issue wins the busy bit
        do_issue(5'd9, 4'd2);
        set_commit(5'd9, 32'hAA, 4'd2);
        bus.issue         = 1'b1;
        bus.issue_rd      = 5'd9;
        bus.issue_rob_pos = 4'd4;
        step();
        idle_inputs();
        chk_rs2("x9_both", 5'd9, 32'hAA, 1'b1, 4'd4);

        // Rollback with same-cycle commit and a dropped issue
        do_issue(5'd1, 4'd1);
        do_issue(5'd2, 4'd2);
        do_issue(5'd31, 4'd5);
        chk_rs1("pre_rb_x31", 5'd31, 32'h0, 1'b1, 4'd5);
        bus.rollback = 1'b1;
        set_commit(5'd1, 32'h55, 4'd1);
        bus.issue         = 1'b1;
        bus.issue_rd      = 5'd10;
        bus.issue_rob_pos = 4'd6;
        step();
        idle_inputs();
        chk_rs1("rb_x1", 5'd1, 32'h55, 1'b0, 4'd0);
        chk_rs2("rb_x2", 5'd2, 32'h0, 1'b0, 4'd0);
        chk_rs1("rb_x31", 5'd31, 32'h0, 1'b0, 4'd0);
        chk_rs2("rb_x10", 5'd10, 32'h0, 1'b0, 4'd0);
        chk_rs2("rb_x9", 5'd9, 32'hAA, 1'b0, 4'd0);

        // x0 ignores issue and commit
        bus.issue         = 1'b1;
        bus.issue_rd      = 5'd0;
        bus.issue_rob_pos = 4'd8;
        set_commit(5'd0, 32'h123, 4'd0);
        chk_rs2("x0_byp", 5'd0, 32'h0, 1'b0, 4'd0);
        check("x0_byp_pos", 64'(bus.rs2_rob_pos), 64'h0);
        step();
        idle_inputs();
        chk_rs2("x0_st", 5'd0, 32'h0, 1'b0, 4'd0);
        check("x0_st_pos", 64'(bus.rs2_rob_pos), 64'h0);

        // rdy low freezes state, including commits
        bus.rdy           = 1'b0;
        bus.issue         = 1'b1;
        bus.issue_rd      = 5'd4;
        bus.issue_rob_pos = 4'd9;
        set_commit(5'd6, 32'h66, 4'd0);
        step();
        step();
        chk_rs1("frz_x4", 5'd4, 32'h0, 1'b0, 4'd0);
        chk_rs2("frz_x6", 5'd6, 32'h0, 1'b0, 4'd0);
        bus.reg_write = 1'b0;
        bus.rdy = 1'b1;
        step();
        idle_inputs();
        chk_rs1("thaw_x4", 5'd4, 32'h0, 1'b1, 4'd9);

        // Asynchronous reset clears mid-cycle without a clock edge
        do_issue(5'd3, 4'hA);
        chk_rs1("pre_rst_x3", 5'd3, 32'h0, 1'b1, 4'hA);
        #1;
        rst = 1'b1;
        #1;
        chk_rs1("arst_x3", 5'd3, 32'h0, 1'b0, 4'd0);
        chk_rs2("arst_x5", 5'd5, 32'h0, 1'b0, 4'd0);
        step();
        rst = 1'b0;
        step();
        chk_rs1("post_rst_x4", 5'd4, 32'h0, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags for the RV32I out-of-order core.
- Sits directly downstream of the reorder buffer's commit port and writes committed results into x1..x31.
- Tells the decoder, for each source operand, either the committed value or the ROB position that will produce it.
- Tracks one outstanding producer per register; on rollback it drops all speculative renames.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- DATA_W, 32, register data width
- ROB_POS_W, 4, ROB index width (ROB_SIZE = 16)

Ports:
- clk, input, 1, clock; all state updates on rising edge
- rst, input, 1, reset, asynchronous, active-high
- rdy, input, 1, global ready; low freezes all state
- rollback, input, 1, mispredict flush from the ROB
- issue, input, 1, decoder issues an instruction this cycle
- issue_rd, input, 5, destination register of the issued instruction
- issue_rob_pos, input, ROB_POS_W, ROB entry allocated to the issued instruction
- reg_write, input, 1, ROB commits a register result
- reg_rd, input, 5, committed destination register
- reg_val, input, DATA_W, committed value
- commit_rob_pos, input, ROB_POS_W, ROB entry being committed
- rs1, input, 5, decoder source-1 index
- rs1_val, output, DATA_W, committed value of rs1 (valid when !rs1_busy)
- rs1_busy, output, 1, rs1 awaits an in-flight producer
- rs1_rob_pos, output, ROB_POS_W, producer ROB entry when rs1_busy
- rs2, rs2_val, rs2_busy, rs2_rob_pos: same as the rs1 group, for source 2

Behaviour:
- State per register:
  - val[i], DATA_W bits
  - busy[i], 1 bit
  - tag[i], ROB_POS_W bits
- Reset (rst high, asynchronous): all val = 0, busy = 0, tag = 0. Query outputs are combinational, so they read 0 / not busy / 0 immediately.
- Query path is combinational on current state, with a commit bypass. For rsN:
  - rsN == 0: val 0, busy 0, rob_pos 0.
  - Else if reg_write && reg_rd == rsN && busy[rsN] && tag[rsN] == commit_rob_pos: val = reg_val, busy 0 (same-cycle forwarding).
  - Else: val[rsN], busy[rsN], tag[rsN].
- The query never sees the rename from a same-cycle issue. Example: `add x5,x5,1` reads the old x5 producer.
- Sequential update, only when rdy = 1 and rst = 0, in priority order:
  1. Commit: if reg_write && reg_rd != 0, then val[reg_rd] <= reg_val. If also busy[reg_rd] && tag[reg_rd] == commit_rob_pos, then busy[reg_rd] <= 0. On tag mismatch the value is written and busy/tag are kept (a younger producer is pending).
  2. Rollback: if rollback, then busy[all] <= 0. Issue is ignored this cycle. The commit value write in the same cycle still takes effect.
  3. Issue: if issue && !rollback && issue_rd != 0, then busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos. This overrides a same-cycle commit busy-clear to the same register.
- x0:
  - Never written; val[0], busy[0] and tag[0] stay 0 permanently.
  - Issue and commit to x0 are ignored.
- rdy = 0: no state change. Query outputs still follow current state and the bypass.
- Latency: a committed value is readable combinationally in the commit cycle (via bypass) and from stored state from the next cycle.
- ROB position wrap-around is handled upstream. Tags are compared for exact equality only, with no ordering arithmetic.

Decomposition:
- Shared macros header (existing convention): REG_POS_WID, DATA_WID, ROB_POS_WID.
- No sub-module is needed. The two read ports are identical, so one local function/generate for the query logic, instantiated for rs1 and rs2.

Test Plan:
- Reset then query: rst pulse with rs1 = 7 → rs1_val 0, rs1_busy 0. Asserting rst mid-operation with x3 busy → busy[3] clears immediately, without waiting for a clock edge.
- Issue then commit:
  - issue rd = 5, rob_pos = 3 → next cycle rs1 = 5 shows busy 1, rob_pos 3.
  - reg_write rd = 5, val 0xDEADBEEF, commit_rob_pos 3 → same cycle rs1 shows val 0xDEADBEEF, busy 0 (bypass); following cycle the same from state.
- Stale commit:
  - issue x5 → pos 3, then issue x5 → pos 7.
  - Commit x5 pos 3, val 0x11 → val[5] = 0x11, busy stays 1, tag 7.
  - Commit pos 7, val 0x22 → busy 0, val 0x22.
- Simultaneous issue and commit to x9: commit pos 2, val 0xAA, and issue x9 pos 4 in the same cycle → next cycle val 0xAA, busy 1, tag 4.
- Rollback:
  - x1, x2 and x31 busy.
  - In one cycle: rollback = 1, reg_write x1 with matching tag and val 0x55, and issue x10.
  - Next cycle: all busy 0, x1 = 0x55, x10 not busy.
- x0 and rdy:
  - issue rd = 0 and commit rd = 0 with val 0x123 → rs2 = 0 reads 0, not busy.
  - With rdy = 0, issue x4 → busy[4] unchanged until rdy returns.
